multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM control unit for the multicycle MIPS datapath; the sequential successor to the single-cycle
//  main/ALU decoders. Sequences each instruction over 3-5 cycles, drives all datapath mux selects, write
//  enables and ALU control, and stalls on a memory-ready handshake. Optional opcodes enabled by parameter.
// PARAMETERS
//  ENABLE_BNE  1  1: decode bne (op 000101) via BRANCH state with inverted zero test; 0: bne is illegal
//  ENABLE_ORI  1  1: decode ori (op 001101) via IEXEC/IWB with zero-extended imm, ALU or; 0: illegal
//  STATE_W     4  state register width (>=4)
// PORTS
//  clk         in   1        rising-edge clock
//  reset_n     in   1        async active-low reset
//  op          in   6        instr[31:26] from instruction register
//  funct       in   6        instr[5:0] from instruction register
//  zero        in   1        ALU zero flag
//  mem_ready   in   1        memory completes access this cycle
//  pcen        out  1        PC load = pcwrite | (branch & (zero ^ is_bne))
//  iord        out  1        mem addr: 0=PC, 1=ALUOut
//  memwrite    out  1        memory write strobe
//  irwrite     out  1        instruction register load
//  regdst      out  1        dest reg: 0=rt, 1=rd
//  memtoreg    out  1        writeback: 0=ALUOut, 1=Data
//  regwrite    out  1        register file write
//  alusrca     out  1        ALU A: 0=PC, 1=rs
//  alusrcb     out  2        ALU B: 00=rt, 01=4, 10=imm ext, 11=imm ext<<2
//  zeroext     out  1        1: zero-extend imm (ori), else sign-extend
//  pcsrc       out  2        00=ALUResult, 01=ALUOut, 10=jump target
//  alucontrol  out  3        010 add, 110 sub, 000 and, 001 or, 111 slt
//  instr_done  out  1        1-cycle pulse in last cycle of each retired instruction
//  illegal_op  out  1        1-cycle pulse in ILLEGAL state
//  state       out  STATE_W  current state (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 IEXEC=9 IWB=10
//   JUMP=11 ILLEGAL=12; other codes -> FETCH next cycle, all enables 0.
//  reset_n=0: state<=FETCH immediately; pcen, irwrite, regwrite, memwrite, instr_done, illegal_op forced 0;
//   other outputs at FETCH values. First fetch begins first rising edge after reset_n rises.
//  Reset mid-instruction aborts it; no partial writes occur after reset_n falls.
//  FETCH: iord=0 alusrca=0 alusrcb=01 add pcsrc=00; holds while mem_ready=0; irwrite=pcen=mem_ready.
//  DECODE: alusrca=0 alusrcb=11 add. Next: lw/sw->MEMADR, R-type->EXEC, beq(/bne)->BRANCH, addi(/ori)->IEXEC,
//   j->JUMP; unknown op, disabled op, or R-type funct not in {add,sub,and,or,slt} -> ILLEGAL.
//  MEMADR: alusrca=1 alusrcb=10 add; lw->MEMRD, sw->MEMWR.
//  MEMRD: iord=1; holds while mem_ready=0; ->MEMWB. MEMWB: regdst=0 memtoreg=1 regwrite=1, instr_done.
//  MEMWR: iord=1 memwrite=1 held until mem_ready=1; instr_done on that cycle; ->FETCH.
//  EXEC: alusrca=1 alusrcb=00, alucontrol from funct; ->ALUWB. ALUWB: regdst=1 regwrite=1, instr_done.
//  BRANCH: alusrca=1 alusrcb=00 sub pcsrc=01 branch=1; taken iff zero (beq) / !zero (bne); instr_done.
//  IEXEC: alusrca=1 alusrcb=10; addi: add zeroext=0; ori: or zeroext=1. IWB: regdst=0 regwrite=1, instr_done.
//  JUMP: pcsrc=10 pcen=1, instr_done. ILLEGAL: illegal_op=1, no writes, ->FETCH.
//  All non-listed outputs 0 per state. alucontrol=010 except where stated. Outputs are functions of state
//   (plus op/funct/zero/mem_ready as noted); IR stable from DECODE onward.
//  Latency with mem_ready=1 (cycles incl. FETCH): lw 5, sw 4, R 4, addi/ori 4, beq/bne 3, j 3, illegal 3.
//  Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle; no timeout.
//  zero ignored outside BRANCH; mem_ready ignored outside FETCH/MEMRD/MEMWR.
// TESTING
//  lw (op 100011), mem_ready=1 -> states 0,1,2,3,4; regwrite+memtoreg only in cycle 5; instr_done once.
//  sw with mem_ready low 2 cycles in MEMWR -> memwrite high 3 cycles, pcen 0 throughout, then FETCH.
//  R-type funct 101010 -> alucontrol=111 in EXEC, regdst=1 regwrite=1 in ALUWB; funct 000000 -> illegal_op.
//  beq zero=1 -> pcen=1 pcsrc=01 in BRANCH; zero=0 -> pcen=0; bne (ENABLE_BNE=1) inverse; ENABLE_BNE=0 -> ILLEGAL.
//  ori (ENABLE_ORI=1) -> IEXEC zeroext=1 alucontrol=001; op 111111 -> ILLEGAL, illegal_op 1 cycle, back to FETCH.
//  reset_n low during MEMWB -> regwrite drops asynchronously, state=0; FETCH stalled by mem_ready=0 -> irwrite=0.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore control FSM for a multicycle MIPS datapath. Steps each
//                instruction through FETCH/DECODE and its class-specific
//                states, drives mux selects, write enables and ALU control,
//                and stalls on the memory-ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter bit ENABLE_BNE = 1'b1,
    parameter bit ENABLE_ORI = 1'b1,
    parameter int STATE_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               zeroext,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_EXEC    = STATE_W'(6),
        S_ALUWB   = STATE_W'(7),
        S_BRANCH  = STATE_W'(8),
        S_IEXEC   = STATE_W'(9),
        S_IWB     = STATE_W'(10),
        S_JUMP    = STATE_W'(11),
        S_ILLEGAL = STATE_W'(12)
    } state_e;

    state_e state_q, state_d;

    logic       w_rtype_ok;
    logic [2:0] w_rtype_alu;
    logic       w_is_bne;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;
    logic       w_done;
    logic       w_illegal;

    // R-type funct decode: legality and the ALU operation it selects
    always_comb begin
        w_rtype_ok  = 1'b1;
        w_rtype_alu = ALU_ADD;
        case (funct)
            6'b100000: w_rtype_alu = ALU_ADD;
            6'b100010: w_rtype_alu = ALU_SUB;
            6'b100100: w_rtype_alu = ALU_AND;
            6'b100101: w_rtype_alu = ALU_OR;
            6'b101010: w_rtype_alu = ALU_SLT;
            default:   w_rtype_ok  = 1'b0;
        endcase
    end

    assign w_is_bne = ENABLE_BNE && (op == OP_BNE);

    // Next-state selection; unused encodings recover to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = w_rtype_ok ? S_EXEC : S_ILLEGAL;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_BNE:       state_d = ENABLE_BNE ? S_BRANCH : S_ILLEGAL;
                    OP_ADDI:      state_d = S_IEXEC;
                    OP_ORI:       state_d = ENABLE_ORI ? S_IEXEC : S_ILLEGAL;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register; asynchronous reset parks the FSM in FETCH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Moore outputs decoded from the current state. The handshake-qualified
    // enables (irwrite/pcen in FETCH, instr_done in MEMWR) and the branch
    // decision must react within the cycle, so outputs are not registered.
    always_comb begin
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zeroext    = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_done     = mem_ready;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = w_rtype_alu;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
                w_done     = 1'b1;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (ENABLE_ORI && (op == OP_ORI)) begin
                    alucontrol = ALU_OR;
                    zeroext    = 1'b1;
                end
            end
            S_IWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
            S_ILLEGAL: w_illegal = 1'b1;
            default: ;
        endcase
    end

    // Write enables and pulses are masked while reset is asserted so that
    // nothing is written between reset_n falling and the next clock edge
    assign pcen       = reset_n & (w_pcwrite | (w_branch & (zero ^ w_is_bne)));
    assign irwrite    = reset_n & w_irwrite;
    assign regwrite   = reset_n & w_regwrite;
    assign memwrite   = reset_n & w_memwrite;
    assign instr_done = reset_n & w_done;
    assign illegal_op = reset_n & w_illegal;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Randomized self-checking bench for multicycle_controller.
//                A per-instruction reference model expands each instruction
//                into its expected cycle-by-cycle output trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       zeroext, instr_done, illegal_op;
    logic [2:0] alucontrol;
    logic [3:0] state;

    // second instance with optional opcodes disabled
    logic [5:0] op2 = 6'b100011;
    logic       mr2 = 1'b0;
    logic       p2, io2, mw2, ir2, rd2, m2r2, rw2, asa2, zx2, dn2, il2;
    logic [1:0] asb2, ps2;
    logic [2:0] alu2;
    logic [3:0] st2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    multicycle_controller #(.ENABLE_BNE(1'b0), .ENABLE_ORI(1'b0), .STATE_W(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .op(op2), .funct(6'b100000), .zero(1'b1),
        .mem_ready(mr2), .pcen(p2), .iord(io2), .memwrite(mw2),
        .irwrite(ir2), .regdst(rd2), .memtoreg(m2r2), .regwrite(rw2),
        .alusrca(asa2), .alusrcb(asb2), .zeroext(zx2), .pcsrc(ps2),
        .alucontrol(alu2), .instr_done(dn2), .illegal_op(il2), .state(st2)
    );

    wire [21:0] w_obs = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg,
                         regwrite, alusrca, alusrcb, zeroext, pcsrc, alucontrol,
                         instr_done, illegal_op};

    typedef struct packed {
        logic [21:0] exp;
        logic        mr;
        logic        z;
    } cyc_t;

    cyc_t q[$];

    function automatic logic [21:0] rec(input int st, input bit pc, input bit io,
            input bit mw, input bit ir, input bit rd, input bit m2r, input bit rw,
            input bit asa, input logic [1:0] asb, input bit zx, input logic [1:0] ps,
            input logic [2:0] alu, input bit dn, input bit il);
        rec = {st[3:0], pc, io, mw, ir, rd, m2r, rw, asa, asb, zx, ps, alu, dn, il};
    endfunction

    function automatic void push(input logic [21:0] e, input logic mr, input logic z);
        cyc_t c;
        c.exp = e;
        c.mr  = mr;
        c.z   = z;
        q.push_back(c);
    endfunction

    // ALU code an R-type funct asks for, or 'x' marker when the funct is not supported
    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            6'h20:   r_alu = 4'b0010;
            6'h22:   r_alu = 4'b0110;
            6'h24:   r_alu = 4'b0000;
            6'h25:   r_alu = 4'b0001;
            6'h2a:   r_alu = 4'b0111;
            default: r_alu = 4'b1000;
        endcase
    endfunction

    // Expand one instruction into its expected trace (default DUT: bne and ori enabled)
    function automatic void model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                  input int fs, input int ms);
        logic [3:0] ra;
        for (int i = 0; i < fs; i++)
            push(rec(0, 0,0,0,0,0,0,0,0, 2'b01, 0, 2'b00, 3'b010, 0,0), 1'b0, 1'($urandom));
        push(rec(0, 1,0,0,1,0,0,0,0, 2'b01, 0, 2'b00, 3'b010, 0,0), 1'b1, 1'($urandom));
        push(rec(1, 0,0,0,0,0,0,0,0, 2'b11, 0, 2'b00, 3'b010, 0,0), 1'($urandom), 1'($urandom));
        ra = r_alu(f);
        if (o == 6'b100011 || o == 6'b101011) begin
            push(rec(2, 0,0,0,0,0,0,0,1, 2'b10, 0, 2'b00, 3'b010, 0,0), 1'($urandom), 1'($urandom));
            if (o == 6'b100011) begin
                for (int i = 0; i < ms; i++)
                    push(rec(3, 0,1,0,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b010, 0,0), 1'b0, 1'($urandom));
                push(rec(3, 0,1,0,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b010, 0,0), 1'b1, 1'($urandom));
                push(rec(4, 0,0,0,0,0,1,1,0, 2'b00, 0, 2'b00, 3'b010, 1,0), 1'($urandom), 1'($urandom));
            end else begin
                for (int i = 0; i < ms; i++)
                    push(rec(5, 0,1,1,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b010, 0,0), 1'b0, 1'($urandom));
                push(rec(5, 0,1,1,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b010, 1,0), 1'b1, 1'($urandom));
            end
        end else if (o == 6'b000000 && !ra[3]) begin
            push(rec(6, 0,0,0,0,0,0,0,1, 2'b00, 0, 2'b00, ra[2:0], 0,0), 1'($urandom), 1'($urandom));
            push(rec(7, 0,0,0,0,1,0,1,0, 2'b00, 0, 2'b00, 3'b010, 1,0), 1'($urandom), 1'($urandom));
        end else if (o == 6'b000100 || o == 6'b000101) begin
            push(rec(8, z ^ (o == 6'b000101), 0,0,0,0,0,0,1, 2'b00, 0, 2'b01, 3'b110, 1,0),
                 1'($urandom), z);
        end else if (o == 6'b001000 || o == 6'b001101) begin
            push(rec(9, 0,0,0,0,0,0,0,1, 2'b10, o == 6'b001101, 2'b00,
                     (o == 6'b001101) ? 3'b001 : 3'b010, 0,0), 1'($urandom), 1'($urandom));
            push(rec(10, 0,0,0,0,0,0,1,0, 2'b00, 0, 2'b00, 3'b010, 1,0), 1'($urandom), 1'($urandom));
        end else if (o == 6'b000010) begin
            push(rec(11, 1,0,0,0,0,0,0,0, 2'b00, 0, 2'b10, 3'b010, 1,0), 1'($urandom), 1'($urandom));
        end else begin
            push(rec(12, 0,0,0,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b010, 0,1), 1'($urandom), 1'($urandom));
        end
    endfunction

    task automatic chk(input string tag, input logic [21:0] exp);
        nvec++;
        assert (w_obs === exp) else begin
            nerr++;
            $error("FAIL %s obs=%h exp=%h", tag, w_obs, exp);
        end
    endtask

    // Replay up to n queued cycles (all when n < 0); inputs change just after posedge
    task automatic run_q(input int n, input string tag);
        cyc_t c;
        int   k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            c = q.pop_front();
            mem_ready = c.mr;
            zero      = c.z;
            @(negedge clk);
            chk($sformatf("%s.c%0d", tag, k), c.exp);
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fs, input int ms, input string tag);
        op    = o;
        funct = f;
        model(o, f, z, fs, ms);
        run_q(-1, tag);
    endtask

    task automatic chk2(input string tag, input logic [3:0] est, input logic eil);
        nvec++;
        assert ({st2, il2} === {est, eil}) else begin
            nerr++;
            $error("FAIL %s obs=%0d/%b exp=%0d/%b", tag, st2, il2, est, eil);
        end
    endtask

    initial begin
        logic [5:0] fl [5];
        logic [5:0] ol [8];
        logic [3:0] es [4];
        cyc_t       c;
        int         k;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        ol = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
               6'b000101, 6'b001000, 6'b001101, 6'b000010};
        es = '{4'd0, 4'd1, 4'd12, 4'd0};

        reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'b0; funct = 6'h20;
        #3;
        chk("reset", rec(0, 0,0,0,0,0,0,0,0, 2'b01, 0, 2'b00, 3'b010, 0,0));
        @(posedge clk); #1;
        chk("reset_hold", rec(0, 0,0,0,0,0,0,0,0, 2'b01, 0, 2'b00, 3'b010, 0,0));
        @(negedge clk);
        mem_ready = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;

        // directed instructions
        do_instr(6'b100011, 6'h00, 1'b0, 0, 0, "lw");
        do_instr(6'b101011, 6'h00, 1'b0, 1, 2, "sw_stall");
        do_instr(6'b000000, 6'h2a, 1'b0, 0, 0, "slt");
        do_instr(6'b000000, 6'h00, 1'b0, 0, 0, "r_illegal");
        do_instr(6'b000100, 6'h00, 1'b1, 0, 0, "beq_t");
        do_instr(6'b000100, 6'h00, 1'b0, 0, 0, "beq_nt");
        do_instr(6'b000101, 6'h00, 1'b1, 0, 0, "bne_nt");
        do_instr(6'b000101, 6'h00, 1'b0, 0, 0, "bne_t");
        do_instr(6'b001101, 6'h00, 1'b0, 0, 0, "ori");
        do_instr(6'b001000, 6'h00, 1'b0, 0, 0, "addi");
        do_instr(6'b000010, 6'h00, 1'b0, 2, 0, "j");
        do_instr(6'b111111, 6'h00, 1'b0, 0, 0, "op_illegal");
        do_instr(6'b100011, 6'h00, 1'b0, 2, 2, "lw_stall");

        // randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 8)       op = ol[k];
            else if (k == 8) op = 6'($urandom);
            else             op = 6'b000000;
            funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 4)];
            do_instr(op, funct, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                     $sformatf("rnd%0d", i));
        end

        // reset asserted during MEMWB must drop regwrite immediately
        op = 6'b100011;
        model(op, funct, 1'b0, 0, 0);
        run_q(4, "lw_pre");
        c = q.pop_front();
        mem_ready = c.mr; zero = c.z;
        @(negedge clk);
        chk("memwb", c.exp);
        #2 reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_async", rec(0, 0,0,0,0,0,0,0,0, 2'b01, 0, 2'b00, 3'b010, 0,0));
        q.delete();
        @(posedge clk); #1;
        chk("rst_mid_hold", rec(0, 0,0,0,0,0,0,0,0, 2'b01, 0, 2'b00, 3'b010, 0,0));
        @(negedge clk);
        mem_ready = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;
        do_instr(6'b000000, 6'h22, 1'b0, 1, 0, "post_rst_sub");

        // optional opcodes disabled: bne and ori both trap
        for (int t = 0; t < 2; t++) begin
            op2 = (t == 0) ? 6'b000101 : 6'b001101;
            mr2 = 1'b1;
            for (int s = 0; s < 4; s++) begin
                if (s == 3) mr2 = 1'b0;
                @(negedge clk);
                chk2($sformatf("dis%0d.c%0d", t, s), es[s], s == 2);
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
